// File: rtl/serial_demux_tx_n_pkg.sv
// Shared constants for the serial demux transmitter: FSM encodings and
// synchronizer depth.
package serial_tx_pkg;

  localparam int SYNC_STAGES = 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GET_CH  = 3'd1;
  localparam logic [2:0] S_GET_LEN = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_PARITY  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

endpackage

// File: rtl/serial_demux_tx_n_if.sv
// Sample stream from the push-button synchronizer to the frame FSM, plus the
// FSM state so checkers can observe it at one point.
interface serial_demux_tx_n_if;
  // smp is a single-cycle strobe; sbit is only meaningful while smp is high.
  // There is no back-pressure: the FSM must consume every strobe.
  logic       smp;
  logic       sbit;
  logic [2:0] state;

  modport master (output smp, output sbit, input  state);
  modport slave  (input  smp, input  sbit, output state);
endinterface

// File: rtl/serial_demux_tx_n_sync.sv
// Synchronizes the push-button strobe and serial line, and turns each rising
// edge of the synced strobe into one registered sample pulse.
module pb_sample_sync
  import serial_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_pb_i,
  input  logic                  ser_i,
  serial_demux_tx_n_if.master   smp_o
);

  logic [SYNC_STAGES-1:0] pb_q;
  logic [SYNC_STAGES-1:0] ser_q;
  logic                   pb_prev_q;
  logic                   smp_q;
  logic                   bit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pb_q      <= '0;
      ser_q     <= '0;
      pb_prev_q <= 1'b0;
      smp_q     <= 1'b0;
      bit_q     <= 1'b0;
    end else begin
      pb_q      <= {pb_q[SYNC_STAGES-2:0], clk_pb_i};
      ser_q     <= {ser_q[SYNC_STAGES-2:0], ser_i};
      pb_prev_q <= pb_q[SYNC_STAGES-1];
      // A held strobe produces one pulse: only the 0->1 transition counts.
      smp_q     <= pb_q[SYNC_STAGES-1] & ~pb_prev_q;
      bit_q     <= ser_q[SYNC_STAGES-1];
    end
  end

  assign smp_o.smp  = smp_q;
  assign smp_o.sbit = bit_q;

endmodule

// File: rtl/serial_demux_tx_n.sv
// Serial frame receiver: start bit, channel address, length, payload, optional
// even parity. Payload bits are routed onto the addressed bit of p.
module serial_demux_tx_n
  import serial_tx_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int LEN_W     = 4,
  parameter  bit PARITY_EN = 1'b1,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkPB,
  input  logic              Ser_In,
  output logic [NUM_CH-1:0] p,
  output logic              SerOutValid,
  output logic              done,
  output logic              parity_err,
  output logic              busy,
  output logic [CH_W-1:0]   ch_cur,
  output logic [LEN_W-1:0]  rem_cnt
);

  localparam logic [2:0] S_TAIL = PARITY_EN ? S_PARITY : S_DONE;

  serial_demux_tx_n_if sif ();

  pb_sample_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .clk_pb_i (clkPB),
    .ser_i    (Ser_In),
    .smp_o    (sif)
  );

  logic [2:0]        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic              acc_q, acc_d;
  logic              perr_q, perr_d;
  logic [NUM_CH-1:0] p_q, p_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;
  logic [CH_W-1:0]   ch_shift;
  logic [LEN_W-1:0]  len_shift;

  assign ch_shift  = CH_W'({ch_q, sif.sbit});
  assign len_shift = LEN_W'({rem_q, sif.sbit});

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rem_d   = rem_q;
    fcnt_d  = fcnt_q;
    acc_d   = acc_q;
    perr_d  = perr_q;
    p_d     = p_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sif.smp && !sif.sbit) begin
          state_d = S_GET_CH;
          perr_d  = 1'b0;
          acc_d   = 1'b0;
          fcnt_d  = '0;
        end
      end
      S_GET_CH: begin
        if (sif.smp) begin
          ch_d = ch_shift;
          if (fcnt_q == 8'(CH_W - 1)) begin
            fcnt_d  = '0;
            state_d = S_GET_LEN;
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
      end
      S_GET_LEN: begin
        if (sif.smp) begin
          rem_d = len_shift;
          if (fcnt_q == 8'(LEN_W - 1)) begin
            fcnt_d  = '0;
            state_d = (len_shift != '0) ? S_DATA : S_TAIL;
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
      end
      S_DATA: begin
        if (sif.smp) begin
          p_d          = '0;
          p_d[ch_q]    = sif.sbit;
          vld_d        = 1'b1;
          acc_d        = acc_q ^ sif.sbit;
          if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
          if (rem_q <= LEN_W'(1)) state_d = S_TAIL;
        end
      end
      S_PARITY: begin
        if (sif.smp) begin
          perr_d  = acc_q ^ sif.sbit;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // done is registered so it lands after any final SerOutValid pulse.
        done_d  = 1'b1;
        p_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      rem_q   <= '0;
      fcnt_q  <= '0;
      acc_q   <= 1'b0;
      perr_q  <= 1'b0;
      p_q     <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rem_q   <= rem_d;
      fcnt_q  <= fcnt_d;
      acc_q   <= acc_d;
      perr_q  <= perr_d;
      p_q     <= p_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign sif.state   = state_q;
  assign p           = p_q;
  assign SerOutValid = vld_q;
  assign done        = done_q;
  assign parity_err  = perr_q;
  assign busy        = (state_q != S_IDLE);
  assign ch_cur      = ch_q;
  assign rem_cnt     = rem_q;

endmodule

// File: tb/tb_serial_demux_tx_n.sv
// Directed bench for serial_demux_tx_n: frames are shifted in bit by bit on
// clkPB strobes and outputs are checked against hand-computed values.
module tb_serial_demux_tx_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_np = 1'b1;
  logic       clkPB = 1'b0;
  logic       Ser_In = 1'b1;
  logic [3:0] p, p_np;
  logic       SerOutValid, done, parity_err, busy;
  logic       vld_np, done_np, perr_np, busy_np;
  logic [1:0] ch_cur, ch_np;
  logic [3:0] rem_cnt, rem_np;

  int checks = 0;
  int fails  = 0;
  int vcnt = 0, dcnt = 0, vcnt_np = 0, dcnt_np = 0;
  logic [3:0] plog[$];

  always #5 clk = ~clk;

  serial_demux_tx_n #(.NUM_CH(4), .LEN_W(4), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .clkPB(clkPB), .Ser_In(Ser_In),
    .p(p), .SerOutValid(SerOutValid), .done(done), .parity_err(parity_err),
    .busy(busy), .ch_cur(ch_cur), .rem_cnt(rem_cnt)
  );

  serial_demux_tx_n #(.NUM_CH(4), .LEN_W(4), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .rst(rst_np), .clkPB(clkPB), .Ser_In(Ser_In),
    .p(p_np), .SerOutValid(vld_np), .done(done_np), .parity_err(perr_np),
    .busy(busy_np), .ch_cur(ch_np), .rem_cnt(rem_np)
  );

  // Continuous observation of pulses and output invariants.
  always @(negedge clk) begin
    if (SerOutValid) begin
      vcnt++;
      plog.push_back(p);
    end
    if (done) dcnt++;
    if (vld_np) vcnt_np++;
    if (done_np) dcnt_np++;
    if (SerOutValid || done) begin
      checks++;
      if (SerOutValid && done) begin
        fails++;
        $display("FAIL valid_done_overlap: both high at %0t", $time);
      end
    end
    if (p != 4'b0) begin
      checks++;
      if ($countones(p) > 1) begin
        fails++;
        $display("FAIL p_onehot: p=%b has more than one bit set", p);
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    Ser_In = b;
    repeat (2) @(negedge clk);
    clkPB = 1'b1;
    repeat (5) @(negedge clk);
    clkPB = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int v0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({p, SerOutValid, done, parity_err, busy, ch_cur, rem_cnt} !== 14'b0) begin
      fails++;
      $display("FAIL reset_outputs: got p=%b v=%b d=%b pe=%b busy=%b ch=%0d rem=%0d, want all 0",
               p, SerOutValid, done, parity_err, busy, ch_cur, rem_cnt);
    end
    v0 = vcnt;
    repeat (20) @(negedge clk);
    checks++;
    if (vcnt !== v0) begin
      fails++;
      $display("FAIL reset_no_valid: got %0d pulses, want 0", vcnt - v0);
    end
  endtask

  task automatic test_frame_parity_ok();
    int v0, d0;
    v0 = vcnt; d0 = dcnt;
    send_bits(16'h023A, 11);  // 0 10 0011 101 0
    checks++;
    if (vcnt - v0 !== 3) begin
      fails++; $display("FAIL frame_valid_cnt: got %0d, want 3", vcnt - v0);
    end else begin
      checks++;
      if (plog[v0] !== 4'b0100 || plog[v0+1] !== 4'b0000 || plog[v0+2] !== 4'b0100) begin
        fails++;
        $display("FAIL frame_p_values: got %b %b %b, want 0100 0000 0100",
                 plog[v0], plog[v0+1], plog[v0+2]);
      end
    end
    checks++;
    if (dcnt - d0 !== 1) begin
      fails++; $display("FAIL frame_done_cnt: got %0d, want 1", dcnt - d0);
    end
    checks++;
    if (parity_err !== 1'b0) begin
      fails++; $display("FAIL frame_parity_err: got %b, want 0", parity_err);
    end
    checks++;
    if (ch_cur !== 2'd2) begin
      fails++; $display("FAIL frame_ch_cur: got %0d, want 2", ch_cur);
    end
    checks++;
    if (rem_cnt !== 4'd0 || busy !== 1'b0 || p !== 4'b0) begin
      fails++;
      $display("FAIL frame_end_state: got rem=%0d busy=%b p=%b, want 0 0 0000", rem_cnt, busy, p);
    end
  endtask

  task automatic test_parity_error();
    int d0;
    d0 = dcnt;
    send_bits(16'h023B, 11);  // same frame, parity bit 1
    checks++;
    if (dcnt - d0 !== 1 || parity_err !== 1'b1) begin
      fails++;
      $display("FAIL parity_err_set: got done=%0d pe=%b, want 1 1", dcnt - d0, parity_err);
    end
    send_bits(16'h0000, 1);   // next start bit
    checks++;
    if (parity_err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL parity_err_clear: got pe=%b busy=%b, want 0 1", parity_err, busy);
    end
    pulse_rst();
  endtask

  task automatic test_zero_len();
    int v0, d0;
    rst_np = 1'b0;
    v0 = vcnt_np; d0 = dcnt_np;
    send_bits(16'h0010, 7);   // 0 01 0000, no parity bit
    checks++;
    if (dcnt_np - d0 !== 1 || vcnt_np !== v0 || busy_np !== 1'b0) begin
      fails++;
      $display("FAIL zero_len_noparity: got done=%0d valid=%0d busy=%b, want 1 0 0",
               dcnt_np - d0, vcnt_np - v0, busy_np);
    end
    rst_np = 1'b1;
    pulse_rst();
    v0 = vcnt; d0 = dcnt;
    send_bits(16'h0020, 8);   // 0 01 0000 0
    checks++;
    if (vcnt !== v0 || dcnt - d0 !== 1) begin
      fails++;
      $display("FAIL zero_len_pulses: got valid=%0d done=%0d, want 0 1", vcnt - v0, dcnt - d0);
    end
    checks++;
    if (parity_err !== 1'b0 || ch_cur !== 2'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_len_state: got pe=%b ch=%0d busy=%b, want 0 1 0", parity_err, ch_cur, busy);
    end
  endtask

  task automatic test_abort();
    int v0, d0;
    send_bits(16'h0017, 9);   // 0 00 0101 1 1, frame still open
    checks++;
    if (p !== 4'b0001 || busy !== 1'b1 || rem_cnt !== 4'd3) begin
      fails++;
      $display("FAIL abort_midframe: got p=%b busy=%b rem=%0d, want 0001 1 3", p, busy, rem_cnt);
    end
    d0 = dcnt;
    pulse_rst();
    @(negedge clk);
    checks++;
    if (p !== 4'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_cleared: got p=%b busy=%b, want 0000 0", p, busy);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (dcnt !== d0) begin
      fails++; $display("FAIL abort_no_done: got %0d done pulses, want 0", dcnt - d0);
    end
    v0 = vcnt; d0 = dcnt;
    send_bits(16'h0195, 10);  // 0 11 0010 10 1
    checks++;
    if (vcnt - v0 !== 2 || dcnt - d0 !== 1) begin
      fails++;
      $display("FAIL after_abort_pulses: got valid=%0d done=%0d, want 2 1", vcnt - v0, dcnt - d0);
    end else begin
      checks++;
      if (plog[v0] !== 4'b1000 || plog[v0+1] !== 4'b0000) begin
        fails++;
        $display("FAIL after_abort_p: got %b %b, want 1000 0000", plog[v0], plog[v0+1]);
      end
    end
    checks++;
    if (parity_err !== 1'b0 || ch_cur !== 2'd3) begin
      fails++;
      $display("FAIL after_abort_state: got pe=%b ch=%0d, want 0 3", parity_err, ch_cur);
    end
  endtask

  task automatic test_idle_and_hold();
    int v0, d0;
    v0 = vcnt; d0 = dcnt;
    send_bits(16'h0007, 3);   // three idle-line 1 bits
    checks++;
    if (busy !== 1'b0 || vcnt !== v0 || dcnt !== d0) begin
      fails++;
      $display("FAIL idle_ones: got busy=%b valid=%0d done=%0d, want 0 0 0",
               busy, vcnt - v0, dcnt - d0);
    end
    @(negedge clk);
    Ser_In = 1'b0;
    repeat (2) @(negedge clk);
    clkPB = 1'b1;
    repeat (50) @(negedge clk);
    clkPB = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL hold_start: got busy=%b, want 1", busy);
    end
    send_bits(16'h00C7, 8);   // 11 0001 1 1
    checks++;
    if (ch_cur !== 2'd3 || vcnt - v0 !== 1 || dcnt - d0 !== 1 || parity_err !== 1'b0) begin
      fails++;
      $display("FAIL hold_single_smp: got ch=%0d valid=%0d done=%0d pe=%b, want 3 1 1 0",
               ch_cur, vcnt - v0, dcnt - d0, parity_err);
    end else begin
      checks++;
      if (plog[v0] !== 4'b1000) begin
        fails++; $display("FAIL hold_p: got %b, want 1000", plog[v0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_parity_ok();
    test_parity_error();
    test_zero_len();
    test_abort();
    test_idle_and_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
